combo_lock_ctrl: RTL and testbench
==================================

# combo_lock_ctrl

Sequencing controller for the combination lock: it collects a fixed-length series of digit entries, compares them against a stored code, and drives the unlocked and lockout indications. It owns the digit-position counting and the failed-attempt counting, and it enforces timed unlock and lockout windows. It sits between the debounced keypad/switch front end and the lock actuator/LED outputs.

## Interface
- `DIGIT_W`, 4: width of one digit.
- `CODE_LEN`, 4: digits per combination; legal range 1–7.
- `DEFAULT_CODE`, 16'h1234: reset code, `CODE_LEN*DIGIT_W` bits; the first digit entered is the MS digit.
- `MAX_FAILS`, 3: consecutive failures that trigger lockout; legal range 1–7.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clk cycles (≥1).
- `UNLOCK_CYCLES`, 500: auto-relock timeout in clk cycles (≥1).

Ports:
- `clk`  in  1: single clock; all logic uses the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `digit_in`  in  DIGIT_W: digit value, qualified by `digit_valid`.
- `digit_valid`  in  1: one-cycle pulse per keypress.
- `clear`  in  1: pulse; abort the current entry.
- `lock_req`  in  1: pulse; relock immediately from UNLOCKED.
- `prog_req`  in  1: pulse; enter programming from UNLOCKED (`COMBO_PROG_EN` only).
- `unlocked`  out  1: high while in UNLOCKED.
- `lockout`  out  1: high while in LOCKOUT.
- `prog_mode`  out  1: high while in PROG.
- `digit_count`  out  3: digits accepted in the current entry.
- `fail_count`  out  3: consecutive failed attempts.
- `fail_pulse`  out  1: one-cycle pulse on each mismatch.

## Operation
- States: ENTRY, CHECK, UNLOCKED, LOCKOUT, PROG.
- Reset values: state=ENTRY; `digit_count`=0; `fail_count`=0; `fail_pulse`=0; `unlocked`=0; `lockout`=0; `prog_mode`=0; entry buffer=0; code register=`DEFAULT_CODE`; timer=0.
- ENTRY:
  - Each `digit_valid` shifts `digit_in` into the entry buffer and increments `digit_count`.
  - On the `CODE_LEN`-th digit, go to CHECK and set `digit_count`=0.
  - `clear` zeroes `digit_count` and does not count as a failure.
  - If `clear` and `digit_valid` arrive together, `clear` wins and the digit is dropped.
- CHECK (1 cycle), comparing the entry buffer to the code register:
  - Match: go to UNLOCKED, `fail_count`=0, timer loaded with `UNLOCK_CYCLES`-1.
  - Mismatch: pulse `fail_pulse` and increment `fail_count`. If the new value equals `MAX_FAILS`, go to LOCKOUT with the timer loaded with `LOCKOUT_CYCLES`-1; otherwise go back to ENTRY.
- UNLOCKED:
  - Timer decrements each cycle; the transition out of UNLOCKED fires on the cycle the timer reads 0.
  - Timeout or `lock_req` → ENTRY.
  - `prog_req` → PROG. If `prog_req` and `lock_req` arrive together, `lock_req` wins.
- LOCKOUT: timer decrements; on 0 go to ENTRY with `fail_count`=0.
- Inputs ignored: `digit_valid`, `clear`, `lock_req` and `prog_req` have no effect in CHECK and LOCKOUT, except where listed for a state above.
- PROG:
  - Collects `CODE_LEN` digits exactly as ENTRY does.
  - On the last digit the buffer is committed to the code register, then → ENTRY (locked).
  - `clear` aborts: code unchanged, → ENTRY.
  - No timeout while in PROG.
- Width rules: `digit_count` and `fail_count` saturate by construction and never exceed `CODE_LEN` and `MAX_FAILS` respectively.

## Timing
- Outputs are registered and decoded from the state and counters; they change only at clk edges, apart from the async reset.
- The last digit sampled at edge N:
  - `unlocked` or `fail_pulse` is visible after edge N+1.
  - `lockout` is visible after edge N+1 on the failure that reaches `MAX_FAILS`.
- `unlocked` stays high for exactly `UNLOCK_CYCLES` cycles unless `lock_req` ends it early.
- `lockout` stays high for exactly `LOCKOUT_CYCLES` cycles.
- A digit arriving on the cycle the state returns to ENTRY is accepted.
- `rst` asserted mid-operation returns all state to reset values immediately; a programmed code reverts to `DEFAULT_CODE`.

## Configuration
- `COMBO_PROG_EN` defined:
  - The PROG state and the code register are present, and `prog_req` is honoured.
- `COMBO_PROG_EN` undefined:
  - No PROG state; `prog_req` is ignored.
  - `prog_mode` is tied to 0.
  - The code is the constant `DEFAULT_CODE`.

## Test plan
- Reset, enter 1,2,3,4 → `unlocked`=1 two edges after the last `digit_valid`, held for `UNLOCK_CYCLES`, then 0; `fail_count`=0.
- Enter 1,2,3,5 three times (`MAX_FAILS`=3, `LOCKOUT_CYCLES`=20):
  - → `fail_pulse` ×3 and `fail_count` 1,2,3; `lockout`=1 for 20 cycles.
  - Digits entered during lockout are ignored; afterwards `fail_count`=0.
- Enter 1,2, assert `clear` together with digit 3, then enter 1,2,3,4 → the dropped digit leaves `digit_count`=0, then unlock; `fail_count` stays 0.
- Unlock, then pulse `lock_req` 5 cycles later → `unlocked` falls on the next edge; a following 1,2,3,4 unlocks again.
- With `COMBO_PROG_EN`:
  - Unlock, `prog_req`, enter 9,8,7,6 → `prog_mode` 1→0 and state is locked.
  - 1,2,3,4 now fails; 9,8,7,6 unlocks.
  - After `rst`, 1,2,3,4 unlocks again.
- Assert `rst` mid-entry after 2 digits and again during lockout → all outputs 0 immediately; a full 1,2,3,4 afterwards unlocks.

Source files
------------

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: collects CODE_LEN digits, compares them against the code,
// and runs timed unlock and lockout windows. Define COMBO_PROG_EN to add the code-programming state.
module combo_lock_ctrl #(
  parameter int unsigned                 DIGIT_W        = 4,
  parameter int unsigned                 CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 1000,
  parameter int unsigned                 UNLOCK_CYCLES  = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               clear,
  input  logic               lock_req,
  input  logic               prog_req,
  output logic               unlocked,
  output logic               lockout,
  output logic               prog_mode,
  output logic [2:0]         digit_count,
  output logic [2:0]         fail_count,
  output logic               fail_pulse
);

  localparam int unsigned CW   = CODE_LEN * DIGIT_W;
  localparam int unsigned TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [2:0]    LAST_IDX    = 3'(CODE_LEN - 1);
  localparam logic [2:0]    MAX_F       = 3'(MAX_FAILS);
  localparam logic [TW-1:0] UNLOCK_LOAD = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKOUT  = 3'd3
`ifdef COMBO_PROG_EN
    , ST_PROG   = 3'd4
`endif
  } state_t;

  // The first digit entered ends up as the most significant digit.
  function automatic logic [CW-1:0] shift_in(input logic [CW-1:0] cur, input logic [DIGIT_W-1:0] d);
    logic [CW-1:0] t;
    t = cur << DIGIT_W;
    t[DIGIT_W-1:0] = d;
    return t;
  endfunction

  state_t        state_q;
  logic [CW-1:0] entry_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    digit_count_q;
  logic [2:0]    fail_count_q;
  logic          fail_pulse_q;
  logic          unlocked_q;
  logic          lockout_q;

  logic [CW-1:0] entry_d;
  logic [2:0]    fail_count_d;
  logic          last_digit_s;
  logic [CW-1:0] code_s;

  assign entry_d      = shift_in(entry_q, digit_in);
  assign fail_count_d = fail_count_q + 3'd1;
  assign last_digit_s = (digit_count_q == LAST_IDX);

`ifdef COMBO_PROG_EN
  logic [CW-1:0] code_q;
  logic          prog_mode_q;
  assign code_s    = code_q;
  assign prog_mode = prog_mode_q;
`else
  logic unused_prog_s;
  assign unused_prog_s = prog_req;
  assign code_s        = DEFAULT_CODE;
  assign prog_mode     = 1'b0;
`endif

  // Main sequencer: state, counters, timer and registered indications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_ENTRY;
      entry_q       <= '0;
      timer_q       <= '0;
      digit_count_q <= 3'd0;
      fail_count_q  <= 3'd0;
      fail_pulse_q  <= 1'b0;
      unlocked_q    <= 1'b0;
      lockout_q     <= 1'b0;
`ifdef COMBO_PROG_EN
      code_q        <= DEFAULT_CODE;
      prog_mode_q   <= 1'b0;
`endif
    end else begin
      fail_pulse_q <= 1'b0;
      case (state_q)
        ST_ENTRY: begin
          if (clear) begin
            digit_count_q <= 3'd0;
          end else if (digit_valid) begin
            entry_q <= entry_d;
            if (last_digit_s) begin
              digit_count_q <= 3'd0;
              state_q       <= ST_CHECK;
            end else begin
              digit_count_q <= digit_count_q + 3'd1;
            end
          end
        end
        ST_CHECK: begin
          if (entry_q == code_s) begin
            state_q      <= ST_UNLOCKED;
            unlocked_q   <= 1'b1;
            fail_count_q <= 3'd0;
            timer_q      <= UNLOCK_LOAD;
          end else begin
            fail_pulse_q <= 1'b1;
            fail_count_q <= fail_count_d;
            if (fail_count_d == MAX_F) begin
              state_q   <= ST_LOCKOUT;
              lockout_q <= 1'b1;
              timer_q   <= LOCK_LOAD;
            end else begin
              state_q <= ST_ENTRY;
            end
          end
        end
        ST_UNLOCKED: begin
          // lock_req outranks prog_req when both arrive together.
          if (lock_req || (timer_q == '0)) begin
            state_q    <= ST_ENTRY;
            unlocked_q <= 1'b0;
          end
`ifdef COMBO_PROG_EN
          else if (prog_req) begin
            state_q       <= ST_PROG;
            unlocked_q    <= 1'b0;
            prog_mode_q   <= 1'b1;
            digit_count_q <= 3'd0;
          end
`endif
          else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (timer_q == '0) begin
            state_q      <= ST_ENTRY;
            lockout_q    <= 1'b0;
            fail_count_q <= 3'd0;
          end else begin
            timer_q <= timer_q - TIMER_ONE;
          end
        end
`ifdef COMBO_PROG_EN
        ST_PROG: begin
          if (clear) begin
            digit_count_q <= 3'd0;
            state_q       <= ST_ENTRY;
            prog_mode_q   <= 1'b0;
          end else if (digit_valid) begin
            entry_q <= entry_d;
            if (last_digit_s) begin
              code_q        <= entry_d;
              digit_count_q <= 3'd0;
              state_q       <= ST_ENTRY;
              prog_mode_q   <= 1'b0;
            end else begin
              digit_count_q <= digit_count_q + 3'd1;
            end
          end
        end
`endif
        default: begin
          state_q    <= ST_ENTRY;
          unlocked_q <= 1'b0;
          lockout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked    = unlocked_q;
  assign lockout     = lockout_q;
  assign digit_count = digit_count_q;
  assign fail_count  = fail_count_q;
  assign fail_pulse  = fail_pulse_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: expected unlock/fail/lockout events are queued with
// their due cycle when a code is entered, and a negedge monitor pops and compares them.
module tb_combo_lock_ctrl;
  localparam int EV_UNLOCK = 0;
  localparam int EV_FAIL   = 1;
  localparam int EV_LOCK   = 2;
  localparam int UNLOCK_N  = 30;
  localparam int LOCK_N    = 20;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       digit_valid, clear, lock_req, prog_req;
  logic       unlocked, lockout, prog_mode, fail_pulse;
  logic [2:0] digit_count, fail_count;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  ev_t sb_q[$];
  logic prev_unl = 1'b0;
  logic prev_lock = 1'b0;

  combo_lock_ctrl #(
    .DIGIT_W(4), .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_FAILS(3),
    .LOCKOUT_CYCLES(LOCK_N), .UNLOCK_CYCLES(UNLOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
    .clear(clear), .lock_req(lock_req), .prog_req(prog_req),
    .unlocked(unlocked), .lockout(lockout), .prog_mode(prog_mode),
    .digit_count(digit_count), .fail_count(fail_count), .fail_pulse(fail_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: each observed event must match the head of the scoreboard, kind and cycle.
  always @(negedge clk) begin
    logic seen [3];
    ev_t  e;
    seen[EV_UNLOCK] = (unlocked === 1'b1) && (prev_unl !== 1'b1);
    seen[EV_FAIL]   = (fail_pulse === 1'b1);
    seen[EV_LOCK]   = (lockout === 1'b1) && (prev_lock !== 1'b1);
    if (rst !== 1'b1) begin
      for (int k = 1; k < 4; k++) begin
        if (seen[k % 3]) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected event kind=%0d at cyc=%0d, none expected", k % 3, cyc);
          end else begin
            e = sb_q.pop_front();
            if (e.kind !== (k % 3) || e.cyc !== cyc) begin
              bad++;
              $display("FAIL sb_event got kind=%0d cyc=%0d want kind=%0d cyc=%0d", k % 3, cyc, e.kind, e.cyc);
            end
          end
        end
      end
    end
    prev_unl  <= unlocked;
    prev_lock <= lockout;
  end

  task automatic send_digit(input logic [3:0] d);
    @(negedge clk);
    digit_in = d;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  // Enter four digits MS first and queue the expected outcome one edge after the last sample.
  task automatic enter4(input logic [15:0] code, input int exp);
    for (int i = 0; i < 4; i++) send_digit(code[15-4*i -: 4]);
    if (exp == EV_UNLOCK) begin
      sb_q.push_back('{EV_UNLOCK, cyc + 1});
    end else begin
      sb_q.push_back('{EV_FAIL, cyc + 1});
      if (exp == EV_LOCK) sb_q.push_back('{EV_LOCK, cyc + 1});
    end
  endtask

  task automatic drain(input string name);
    int b = 50;
    while (sb_q.size() != 0 && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d want pending=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic pulse_lock_req();
    @(negedge clk);
    lock_req = 1'b1;
    @(negedge clk);
    lock_req = 1'b0;
    total++;
    if (unlocked !== 1'b0) begin
      bad++;
      $display("FAIL lock_req_relock got unlocked=%b want 0", unlocked);
    end
  endtask

  task automatic check_idle(input string name);
    logic [9:0] obs;
    obs = {unlocked, lockout, prog_mode, fail_pulse, digit_count, fail_count};
    total++;
    if (obs !== 10'h000) begin
      bad++;
      $display("FAIL %s got outputs=%h want 000", name, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
  endtask

  task automatic test_unlock();
    int n = 0;
    enter4(16'h1234, EV_UNLOCK);
    drain("unlock");
    while (unlocked === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== UNLOCK_N) begin
      bad++;
      $display("FAIL unlock_duration got %0d want %0d", n, UNLOCK_N);
    end
    total++;
    if (fail_count !== 3'd0) begin
      bad++;
      $display("FAIL unlock_fail_count got %0d want 0", fail_count);
    end
  endtask

  task automatic test_lockout();
    int n = 0;
    for (int i = 1; i <= 3; i++) begin
      enter4(16'h1235, (i == 3) ? EV_LOCK : EV_FAIL);
      drain("fail");
      total++;
      if (fail_count !== 3'(i)) begin
        bad++;
        $display("FAIL fail_count_step got %0d want %0d", fail_count, i);
      end
    end
    total++;
    if (lockout !== 1'b1) begin
      bad++;
      $display("FAIL lockout_set got %b want 1", lockout);
    end
    while (lockout === 1'b1 && n < 200) begin
      digit_valid = (n < 8) ? 1'b1 : 1'b0;
      digit_in = 4'(n % 4 + 1);
      @(negedge clk);
      n++;
    end
    digit_valid = 1'b0;
    total++;
    if (n !== LOCK_N) begin
      bad++;
      $display("FAIL lockout_duration got %0d want %0d", n, LOCK_N);
    end
    check_idle("after_lockout");
  endtask

  task automatic test_clear();
    send_digit(4'd1);
    send_digit(4'd2);
    total++;
    if (digit_count !== 3'd2) begin
      bad++;
      $display("FAIL clear_pre_count got %0d want 2", digit_count);
    end
    @(negedge clk);
    digit_in = 4'd3;
    digit_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    clear = 1'b0;
    check_idle("clear_dropped_digit");
    enter4(16'h1234, EV_UNLOCK);
    drain("clear_unlock");
    total++;
    if (fail_count !== 3'd0) begin
      bad++;
      $display("FAIL clear_fail_count got %0d want 0", fail_count);
    end
    pulse_lock_req();
  endtask

  task automatic test_lock_req();
    enter4(16'h1234, EV_UNLOCK);
    drain("lockreq_unlock");
    repeat (4) @(negedge clk);
    total++;
    if (unlocked !== 1'b1) begin
      bad++;
      $display("FAIL lockreq_still_open got %b want 1", unlocked);
    end
    pulse_lock_req();
    enter4(16'h1234, EV_UNLOCK);
    drain("lockreq_reunlock");
    pulse_lock_req();
  endtask

  task automatic test_back_to_back();
    enter4(16'h1235, EV_FAIL);
    enter4(16'h1234, EV_UNLOCK);
    drain("b2b");
    total++;
    if (fail_count !== 3'd0) begin
      bad++;
      $display("FAIL b2b_fail_count got %0d want 0", fail_count);
    end
    pulse_lock_req();
  endtask

  task automatic test_prog();
    enter4(16'h1234, EV_UNLOCK);
    drain("prog_unlock");
    @(negedge clk);
    prog_req = 1'b1;
    @(negedge clk);
    prog_req = 1'b0;
`ifdef COMBO_PROG_EN
    total++;
    if ({prog_mode, unlocked} !== 2'b10) begin
      bad++;
      $display("FAIL prog_enter got prog/unl=%b%b want 10", prog_mode, unlocked);
    end
    send_digit(4'd9);
    send_digit(4'd8);
    send_digit(4'd7);
    total++;
    if (prog_mode !== 1'b1) begin
      bad++;
      $display("FAIL prog_hold got %b want 1", prog_mode);
    end
    send_digit(4'd6);
    check_idle("prog_commit");
    enter4(16'h1234, EV_FAIL);
    drain("prog_oldcode");
    enter4(16'h9876, EV_UNLOCK);
    drain("prog_newcode");
    pulse_lock_req();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enter4(16'h1234, EV_UNLOCK);
    drain("prog_revert");
    pulse_lock_req();
`else
    total++;
    if ({prog_mode, unlocked} !== 2'b01) begin
      bad++;
      $display("FAIL prog_ignored got prog/unl=%b%b want 01", prog_mode, unlocked);
    end
    pulse_lock_req();
`endif
  endtask

  task automatic test_rst_mid();
    send_digit(4'd1);
    send_digit(4'd2);
    rst = 1'b1;
    #1;
    check_idle("rst_mid_entry");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enter4(16'h4321, (i == 2) ? EV_LOCK : EV_FAIL);
      drain("rst_fail");
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("rst_mid_lockout");
    @(negedge clk);
    rst = 1'b0;
    enter4(16'h1234, EV_UNLOCK);
    drain("rst_unlock");
    pulse_lock_req();
  endtask

  initial begin
    rst = 1'b1;
    digit_in = 4'd0;
    digit_valid = 1'b0;
    clear = 1'b0;
    lock_req = 1'b0;
    prog_req = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_lock_req();
    test_back_to_back();
    test_prog();
    test_rst_mid();
    repeat (3) @(negedge clk);
    drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
